// File: rtl/bin2disp_formatter.sv
// Signed binary to 7-segment digit formatter: iterative double dabble
// conversion followed by leading-zero blanking and a floating minus sign.
module bin2disp_formatter #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      valor,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digito,
    output logic [DIGITS-1:0]     apaga,
    output logic [DIGITS-1:0]     sinal
);

    // Decimal digits needed for 2^(WIDTH-1), the largest magnitude.
    function automatic int bcd_digits(input int w);
        longint v;
        int     d;
        v = longint'(1) << (w - 1);
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > 0) begin
                d++;
                v = v / 10;
            end
        end
        return d;
    endfunction

    localparam int BCDN = bcd_digits(WIDTH);
    localparam int NB   = (BCDN > DIGITS) ? BCDN : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FORMAT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WIDTH-1:0]  mag;
    logic [4*NB-1:0]   bcd;
    logic [4*NB-1:0]   adj;
    logic              neg;
    logic [CW-1:0]     cnt;

    logic [4*DIGITS-1:0] digito_n;
    logic [DIGITS-1:0]   apaga_n;
    logic [DIGITS-1:0]   sinal_n;
    logic                ovf_n;
    int                  top;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_n = FORMAT;
            FORMAT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Display pattern derived from the finished BCD register.
    always_comb begin
        top      = 1;
        digito_n = '0;
        apaga_n  = '0;
        sinal_n  = '0;
        for (int i = 0; i < NB; i++) begin
            if (bcd[4*i +: 4] != 4'd0) top = i + 1;
        end
        ovf_n = neg ? (top >= DIGITS) : (top > DIGITS);
        for (int p = 0; p < DIGITS; p++) begin
            if (ovf_n) begin
                sinal_n[p] = 1'b1;
            end else if (p < top) begin
                digito_n[4*p +: 4] = bcd[4*p +: 4];
            end else if (neg && p == top) begin
                sinal_n[p] = 1'b1;
            end else begin
                apaga_n[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag      <= '0;
            bcd      <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            digito   <= '0;
            apaga    <= '1;
            sinal    <= '0;
        end else begin
            busy <= (state_n != IDLE);
            done <= (state == FORMAT);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        neg <= valor[WIDTH-1];
                        mag <= valor[WIDTH-1]
                             ? (~valor + {{(WIDTH-1){1'b0}}, 1'b1})
                             : valor;
                        bcd <= '0;
                        cnt <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {adj, mag} << 1;
                    cnt        <= cnt - CW'(1);
                end
                FORMAT: begin
                    digito   <= digito_n;
                    apaga    <= apaga_n;
                    sinal    <= sinal_n;
                    overflow <= ovf_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2disp_formatter.sv
// Scoreboard bench for bin2disp_formatter: an integer model predicts the
// display pattern for each accepted value, compared when done pulses.
module tb_bin2disp_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] valor = '0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] digito;
    logic [3:0]  apaga;
    logic [3:0]  sinal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          v;
        logic [15:0] dg;
        logic [3:0]  ap;
        logic [3:0]  sg;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    bin2disp_formatter #(.WIDTH(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .valor    (valor),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digito   (digito),
        .apaga    (apaga),
        .sinal    (sinal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int   m, n, p10;
        int   d[6];
        bit   ng;
        ng  = (v < 0);
        m   = ng ? -v : v;
        p10 = 1;
        n   = 1;
        for (int i = 0; i < 6; i++) begin
            d[i] = (m / p10) % 10;
            if (d[i] != 0) n = i + 1;
            p10 = p10 * 10;
        end
        e.v  = v;
        e.dg = '0;
        e.ap = '0;
        e.sg = '0;
        e.ov = ng ? (n >= 4) : (n > 4);
        for (int p = 0; p < 4; p++) begin
            if (e.ov) e.sg[p] = 1'b1;
            else if (p < n) e.dg[4*p +: 4] = 4'(d[p]);
            else if (ng && p == n) e.sg[p] = 1'b1;
            else e.ap[p] = 1'b1;
        end
        return e;
    endfunction

    task automatic run(input int v, input bit poke);
        int   nb;
        int   k;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        valor = 14'(v);
        sb.push_back(model(v));
        @(negedge clk);
        start = 1'b0;
        valor = 14'($urandom);
        nb = 0;
        k  = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            start = poke && (k == 5);
            if (poke && k == 5) valor = 14'(-1);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk($sformatf("done_seen[%0d]", v), 32'(done), 32'd1);
        chk($sformatf("busy_len[%0d]", v), 32'(nb), 32'd15);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else if (done) begin
            e = sb.pop_front();
            chk($sformatf("digito[%0d]", e.v), 32'(digito), 32'(e.dg));
            chk($sformatf("apaga[%0d]", e.v), 32'(apaga), 32'(e.ap));
            chk($sformatf("sinal[%0d]", e.v), 32'(sinal), 32'(e.sg));
            chk($sformatf("ovf[%0d]", e.v), 32'(overflow), 32'(e.ov));
        end else begin
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_digito"}, 32'(digito), 32'd0);
        chk({tag, "_apaga"}, 32'(apaga), 32'hF);
        chk({tag, "_sinal"}, 32'(sinal), 32'd0);
    endtask

    initial begin
        int ndone;
        int rv;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset("rst");

        run(0, 1'b0);
        run(1234, 1'b1);
        run(-45, 1'b0);
        run(-999, 1'b0);
        run(-1234, 1'b0);
        run(7, 1'b0);
        run(-8192, 1'b0);
        run(8191, 1'b0);
        run(-100, 1'b0);
        run(9, 1'b0);

        // Abort a conversion with reset partway through.
        @(negedge clk);
        start = 1'b1;
        valor = 14'(5555);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset("abort");
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);

        run(42, 1'b0);
        for (int i = 0; i < 6; i++) begin
            rv = int'($urandom_range(0, 16383)) - 8192;
            run(rv, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2disp_formatter.md
# bin2disp_formatter

Sequential signed-binary-to-display formatter. Sits directly upstream of the per-digit 7-segment decoders. It converts a two's-complement value to BCD with an iterative shift-add-3 (double dabble), one bit per clock. It then drives each decoder's nibble, blank (`apaga`) and minus-sign (`sinal`) inputs with leading-zero blanking and a floating minus sign.

## Interface
Parameters:
- `WIDTH`, 14: width of the signed input value (two's complement).
- `DIGITS`, 4: number of display positions driven; index 0 = rightmost (units).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: conversion request. Sampled only while `busy`=0.
- `valor`, in, WIDTH: signed value to display. Captured on the accepted `start` edge.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: one-cycle pulse when new display outputs become valid.
- `overflow`, out, 1: last converted value did not fit in `DIGITS` positions.
- `digito`, out, 4*DIGITS: BCD nibble per position; position i is bits [4i+3:4i].
- `apaga`, out, DIGITS: per-position blank request to the decoders.
- `sinal`, out, DIGITS: per-position minus-sign request to the decoders.

## Operation
- States: IDLE, SHIFT, FORMAT.
- IDLE:
  - `start`=1 captures `valor` and computes the magnitude.
  - Negative values are negated. The magnitude is held in WIDTH bits unsigned, so -2^(WIDTH-1) is represented exactly.
  - Clears the internal BCD register, loads the bit counter with WIDTH, and goes to SHIFT.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble that is ≥5, then shift {BCD, magnitude} left by one.
  - The internal BCD register is sized to hold 2^(WIDTH-1) with no truncation.
  - After WIDTH shifts, go to FORMAT.
- FORMAT, one cycle, then IDLE. All display outputs are written together in this cycle:
  - `n` = index of the most significant nonzero BCD digit + 1. If the value is 0, `n`=1.
  - Positions below `n`: `digito` = BCD digit, `apaga`=0, `sinal`=0.
  - If negative, position `n`: `sinal`=1, `apaga`=0, `digito`=0.
  - All remaining positions: `apaga`=1, `sinal`=0, `digito`=0.
  - Overflow occurs when `n` > DIGITS (non-negative) or `n` ≥ DIGITS (negative). On overflow: `overflow`=1, all `sinal`=1, all `apaga`=0, all `digito`=0, so the display reads all dashes.
- Between conversions, display outputs and `overflow` hold their last value.
- `start` while `busy`=1 is ignored; no queueing.
- `valor` changes after capture do not affect the conversion in progress.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State IDLE; `busy`=0, `done`=0, `overflow`=0.
  - `digito`=0, `apaga` all 1, `sinal`=0.
  - Reset mid-conversion aborts it and applies these same values.
- Accepted `start` at edge E0:
  - `busy`=1 from E0 to E(WIDTH+1).
  - Shifts occur at edges E1..E(WIDTH).
  - FORMAT writes outputs at E(WIDTH+1); `done`=1 and `busy`=0 for the following cycle.
  - Latency is WIDTH+1 cycles (15 with defaults). A new `start` is accepted at E(WIDTH+2) at the earliest.
- `start` held high continuously: back-to-back conversions every WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `valor`=0 with `start` → after 15 cycles `done`=1; `digito`[3:0]=0; `apaga`=4'b1110; `sinal`=0; `overflow`=0.
- `valor`=1234 → `digito`=16'h1234, `apaga`=0, `sinal`=0. Confirm `busy` is high for exactly 15 cycles, and a `start` pulse mid-conversion is ignored.
- `valor`=-45 → `digito`=16'h0045, `sinal`=4'b0100, `apaga`=4'b1000. `valor`=-999 → `digito`=16'h0999, `sinal`=4'b1000, `apaga`=0.
- `valor`=-1234 (needs 5 positions) → `overflow`=1, `sinal`=4'b1111, `apaga`=0. A following `valor`=7 → `overflow`=0, `apaga`=4'b1110.
- `valor`=-8192 (most negative) → `overflow`=1. `valor`=8191 → `digito`=16'h8191, `overflow`=0.
- Assert `rst_n`=0 at cycle 7 of a conversion → outputs at reset values, `busy`=0, no `done` pulse. A subsequent conversion completes normally.
